dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Requester-side controller for the single-port data_memory (MemRead/MemWrite/address/write_data/read_data).
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Translates the byte address into a word index and sequences the memory strobes.
- Returns a response (read data or error) over a valid/ready handshake.

Parameters:
- W, 32, data and request-address width in bits.
- N, 5, memory word-address width; depth is 2**N words; requires W >= N+2.
- RD_LAT, 1, cycles from mem_read assertion to valid mem_read_data; range 1..7.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  W  byte address.
- req_wdata  in  W  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  core accepts the response.
- rsp_rdata  out  W  load data; 0 for stores and errors.
- rsp_error  out  1  misaligned or out-of-range access.
- mem_read  out  1  to data_memory MemRead.
- mem_write  out  1  to data_memory MemWrite.
- mem_address  out  N  to data_memory address.
- mem_write_data  out  W  to data_memory write_data.
- mem_read_data  in  W  from data_memory read_data.

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0 except req_ready=1; without the scrub feature, req_ready returns to 1 on the first clock after release.
- FSM states: IDLE, WRITE, READ, RESP.
- IDLE:
  - req_ready=1. Handshake = req_valid && req_ready; capture req_we, req_addr and req_wdata into registers.
  - Error check: req_addr[1:0]!=0 or req_addr[W-1:N+2]!=0 -> RESP with rsp_error=1, rsp_rdata=0, no memory strobe.
  - Otherwise mem_address=req_addr[N+1:2]; req_we=1 -> WRITE, else -> READ.
- WRITE: mem_write=1 for exactly 1 cycle, with mem_address and mem_write_data stable from the registers -> RESP.
- READ:
  - mem_read=1 and held, with mem_address stable.
  - A 3-bit counter counts RD_LAT cycles; on the last one, register mem_read_data into rsp_rdata and go to RESP.
  - mem_read drops on entry to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_error are stable until rsp_valid && rsp_ready, then -> IDLE.
  - req_ready=0 everywhere except IDLE, so there is never more than one request outstanding.
- Latency:
  - Store: request accept -> rsp_valid 2 cycles.
  - Load: request accept -> rsp_valid RD_LAT+1 cycles.
  - Error: request accept -> rsp_valid 1 cycle.
  - Back-to-back throughput is bounded by one rsp_ready cycle plus one IDLE cycle per request.
- mem_read and mem_write are never asserted in the same cycle; both are 0 in IDLE and RESP.
- Address 0x7C (word 31) is valid; 0x80 is an out-of-range error at N=5; there is no wrap-around.
- Reset mid-operation: strobes deassert immediately (async); any pending response is dropped; no partial write beyond the current cycle.
- req_* inputs are ignored outside IDLE; a changing req_wdata during WRITE has no effect.

Optional Feature:
- Macro DMEM_SCRUB_EN.
- Defined:
  - After reset release, a SCRUB state precedes IDLE and writes 0 to words 0..2**N-1, one per cycle (mem_write=1, mem_write_data=0, mem_address=counter).
  - req_ready=0 and rsp_valid=0 throughout; IDLE is entered on the cycle after word 2**N-1.
  - Reset during scrub restarts it at word 0.
- Undefined: no SCRUB state exists; the reset state goes directly to IDLE.

Decomposition:
- Package dmem_pkg:
  - state typedef enum logic [2:0] {IDLE, WRITE, READ, RESP, SCRUB}.
  - constant BYTE_OFS=2.
  - function addr_ok(addr) implementing the alignment/range check.
- One sub-module, dmem_lat_cnt: loadable down-counter with done flag.
  - Used for the RD_LAT wait; under DMEM_SCRUB_EN, the same RTL with N bits is used as the scrub address counter.

Test Plan:
- Store: req_we=1, addr=0x0C, wdata=0xDEADBEEF -> next cycle mem_write=1 for 1 cycle, mem_address=3, mem_write_data=0xDEADBEEF; rsp_valid 2 cycles after accept, rsp_error=0, rsp_rdata=0.
- Load after store (RD_LAT=1, real data_memory attached): load addr=0x0C -> mem_read=1 for 1 cycle at mem_address=3; rsp_rdata=0xDEADBEEF on rsp_valid.
- Errors: addr=0x0E -> rsp_error=1 one cycle after accept, no mem_read/mem_write. Repeat with addr=0x80 -> same.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load -> rsp_valid and rsp_rdata stable, req_ready=0; release -> IDLE next cycle, and a new request is accepted there.
- Reset mid-load (RD_LAT=3, rst low during the 2nd wait cycle) -> mem_read=0 immediately, rsp_valid=0, req_ready=1 after release; a following store to 0x7C succeeds.
- DMEM_SCRUB_EN with 32 words: after reset release, observe 32 consecutive writes of 0 to addresses 0..31; req_ready rises on cycle 33; loading 0x40 returns 0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory requester controller.
// State encoding includes SCRUB, reachable only when DMEM_SCRUB_EN is defined.
package dmem_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        RESP  = 3'd3,
        SCRUB = 3'd4
    } state_t;

    localparam int BYTE_OFS = 2;

    // Word-aligned and inside the 2**n word window; callers zero-extend to 64 bits.
    function automatic logic addr_ok(input logic [63:0] addr, input int n);
        logic [63:0] w_hi;
        w_hi = addr >> (n + BYTE_OFS);
        return (addr[BYTE_OFS-1:0] == '0) && (w_hi == '0);
    endfunction

endpackage

// File: rtl/dmem_lat_cnt.sv
// Loadable down-counter with a terminal-count (zero) flag.
// Holds at zero; the reset value is a parameter so it can double as a scrub address counter.
module dmem_lat_cnt #(
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_cnt,
    output logic             o_done
);

    logic [WIDTH-1:0] r_cnt;
    logic             w_done;

    assign w_done = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= RST_VAL;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && !w_done) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = w_done;

endmodule

// File: rtl/dmem_access_ctrl.sv
// Requester-side controller for a single-port data memory: one load/store at a time.
// Optional DMEM_SCRUB_EN: zero every memory word after reset before accepting requests.
module dmem_access_ctrl
    import dmem_pkg::*;
#(
    parameter int W      = 32,
    parameter int N      = 5,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [W-1:0] req_addr,
    input  logic [W-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_rdata,
    output logic         rsp_error,
    output logic         mem_read,
    output logic         mem_write,
    output logic [N-1:0] mem_address,
    output logic [W-1:0] mem_write_data,
    input  logic [W-1:0] mem_read_data
);

`ifdef DMEM_SCRUB_EN
    localparam state_t RST_STATE = SCRUB;
`else
    localparam state_t RST_STATE = IDLE;
`endif

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_addr;
    logic [W-1:0]   r_wdata;
    logic [W-1:0]   r_rdata;
    logic           r_error;
    logic           w_accept;
    logic           w_ok;
    logic           w_lat_done;
    logic [2:0]     w_unused_lat_cnt;

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_ok     = addr_ok(64'(req_addr), N);

    // Loaded with RD_LAT-1 at accept so the last READ cycle is the one where it reads zero.
    dmem_lat_cnt #(
        .WIDTH   (3),
        .RST_VAL (3'd0)
    ) u_lat_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_load_val (3'(RD_LAT - 1)),
        .i_en       (r_state == READ),
        .o_cnt      (w_unused_lat_cnt),
        .o_done     (w_lat_done)
    );

`ifdef DMEM_SCRUB_EN
    logic [N-1:0] w_scrub_cnt;
    logic         w_scrub_done;

    // Counts down from all-ones; the inverted count walks word 0 upward.
    dmem_lat_cnt #(
        .WIDTH   (N),
        .RST_VAL ({N{1'b1}})
    ) u_scrub_cnt (
        .clk        (clk),
        .rst        (rst),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_en       (r_state == SCRUB),
        .o_cnt      (w_scrub_cnt),
        .o_done     (w_scrub_done)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RST_STATE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_addr  <= req_addr[N+BYTE_OFS-1:BYTE_OFS];
                r_wdata <= req_wdata;
                r_rdata <= '0;
                r_error <= !w_ok;
            end else if ((r_state == READ) && w_lat_done) begin
                r_rdata <= mem_read_data;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (!w_ok)       w_next = RESP;
                    else if (req_we) w_next = WRITE;
                    else             w_next = READ;
                end
            end
            WRITE: w_next = RESP;
            READ:  if (w_lat_done) w_next = RESP;
            RESP:  if (rsp_ready)  w_next = IDLE;
`ifdef DMEM_SCRUB_EN
            SCRUB: if (w_scrub_done) w_next = IDLE;
`endif
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready      = (r_state == IDLE);
        rsp_valid      = (r_state == RESP);
        rsp_rdata      = (r_state == RESP) ? r_rdata : '0;
        rsp_error      = (r_state == RESP) && r_error;
        mem_read       = (r_state == READ);
        mem_write      = (r_state == WRITE);
        mem_address    = r_addr;
        mem_write_data = (r_state == WRITE) ? r_wdata : '0;
`ifdef DMEM_SCRUB_EN
        if (r_state == SCRUB) begin
            mem_write   = 1'b1;
            mem_address = ~w_scrub_cnt;
        end
`endif
    end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: two instances (RD_LAT=1 and RD_LAT=3), each with a memory model.
// Honours DMEM_SCRUB_EN for the reset-time expectations.
module tb_dmem_access_ctrl;

    localparam int W = 32;
    localparam int N = 5;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic         req_valid [2];
    logic         req_ready [2];
    logic         req_we    [2];
    logic [W-1:0] req_addr  [2];
    logic [W-1:0] req_wdata [2];
    logic         rsp_valid [2];
    logic         rsp_ready [2];
    logic [W-1:0] rsp_rdata [2];
    logic         rsp_error [2];
    logic         mem_read  [2];
    logic         mem_write [2];
    logic [N-1:0] mem_address    [2];
    logic [W-1:0] mem_write_data [2];
    logic [W-1:0] mem_read_data  [2];

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];

    dmem_access_ctrl #(.W(W), .N(N), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_error(rsp_error[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_address(mem_address[0]),
        .mem_write_data(mem_write_data[0]), .mem_read_data(mem_read_data[0])
    );

    dmem_access_ctrl #(.W(W), .N(N), .RD_LAT(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_error(rsp_error[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_address(mem_address[1]),
        .mem_write_data(mem_write_data[1]), .mem_read_data(mem_read_data[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Memory model: data is only valid once mem_read has been held for RD_LAT cycles.
    logic [W-1:0] mem [2][32];
    int           rd_cnt [2];

    initial begin
        for (int d = 0; d < 2; d++) begin
            rd_cnt[d] = 0;
            for (int i = 0; i < 32; i++) mem[d][i] = 32'hA500_0000 | 32'(i);
        end
        forever begin
            @(posedge clk);
            for (int d = 0; d < 2; d++) begin
                if (mem_write[d]) mem[d][mem_address[d]] <= mem_write_data[d];
                rd_cnt[d] <= mem_read[d] ? rd_cnt[d] + 1 : 0;
            end
        end
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            mem_read_data[d] = (mem_read[d] && (rd_cnt[d] >= lat_of(d) - 1))
                               ? mem[d][mem_address[d]] : 32'hBAD0_BAD0;
        end
    end

    int           n_wr [2] = '{0, 0};
    int           n_rd [2] = '{0, 0};
    logic [N-1:0] wr_addr [2];
    logic [W-1:0] wr_data [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (mem_write[d]) begin
                n_wr[d]    = n_wr[d] + 1;
                wr_addr[d] = mem_address[d];
                wr_data[d] = mem_write_data[d];
            end
            if (mem_read[d]) n_rd[d] = n_rd[d] + 1;
            n_cmp = n_cmp + 1;
            if (mem_read[d] && mem_write[d]) begin
                n_bad = n_bad + 1;
                $display("FAIL strobe_excl dut%0d: mem_read and mem_write both 1, required at most one", d);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold);
        int          cyc;
        int          lat_exp;
        int          wr0;
        int          rd0;
        bit          got;
        exp_t        e;
        logic [31:0] held;

        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!req_ready[d] && cyc < 100);
        check("req_ready_wait", 32'(req_ready[d]), 32'd1);
        #1;
        wr0 = n_wr[d];
        rd0 = n_rd[d];
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sbq.push_back(e);
        lat_exp = exp_err ? 1 : (we ? 2 : lat_of(d) + 1);

        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        req_we[d]    = 1'($urandom_range(0, 1));
        req_addr[d]  = $urandom;
        req_wdata[d] = $urandom;

        cyc = 0;
        got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid[d]) got = 1;
        end
        check("rsp_latency", got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(lat_exp));

        if (got) begin
            held = rsp_rdata[d];
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("bp_rsp_valid", 32'(rsp_valid[d]), 32'd1);
                check("bp_rsp_rdata", rsp_rdata[d], held);
                check("bp_req_ready", 32'(req_ready[d]), 32'd0);
            end
            rsp_ready[d] = 1'b1;
        end
        e = sbq.pop_front();
        check("rsp_rdata", rsp_rdata[d], e.rdata);
        check("rsp_error", 32'(rsp_error[d]), 32'(e.err));

        @(posedge clk);
        #1;
        rsp_ready[d] = 1'b0;
        @(negedge clk);
        #1;
        check("post_rsp_valid", 32'(rsp_valid[d]), 32'd0);
        check("post_req_ready", 32'(req_ready[d]), 32'd1);
        check("n_mem_write", 32'(n_wr[d] - wr0), (we && !exp_err) ? 32'd1 : 32'd0);
        check("n_mem_read", 32'(n_rd[d] - rd0), (!we && !exp_err) ? 32'(lat_of(d)) : 32'd0);
        if (we && !exp_err) begin
            check("wr_address", 32'(wr_addr[d]), 32'(addr[6:2]));
            check("wr_data", wr_data[d], wdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    vec_t         vecs [12];
    logic [31:0]  init40;
    logic         ready_in_rst;

    initial begin
`ifdef DMEM_SCRUB_EN
        init40       = 32'h0;
        ready_in_rst = 1'b0;
`else
        init40       = 32'hA500_0010;
        ready_in_rst = 1'b1;
`endif
        //            we    addr            wdata          exp_rdata      err   hold
        vecs[0]  = '{1'b1, 32'h0000_000C, 32'hDEAD_BEEF, 32'h0,         1'b0, 0};
        vecs[1]  = '{1'b0, 32'h0000_000C, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
        vecs[2]  = '{1'b0, 32'h0000_000E, 32'h0,         32'h0,         1'b1, 0};
        vecs[3]  = '{1'b0, 32'h0000_0080, 32'h0,         32'h0,         1'b1, 0};
        vecs[4]  = '{1'b1, 32'h0000_0080, 32'h1111_1111, 32'h0,         1'b1, 0};
        vecs[5]  = '{1'b1, 32'h0000_007C, 32'h1234_5678, 32'h0,         1'b0, 0};
        vecs[6]  = '{1'b0, 32'h0000_007C, 32'h0,         32'h1234_5678, 1'b0, 5};
        vecs[7]  = '{1'b1, 32'h0000_0001, 32'h2222_2222, 32'h0,         1'b1, 2};
        vecs[8]  = '{1'b0, 32'h0000_0040, 32'h0,         init40,        1'b0, 0};
        vecs[9]  = '{1'b1, 32'h0000_0000, 32'hCAFE_F00D, 32'h0,         1'b0, 0};
        vecs[10] = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_F00D, 1'b0, 0};
        vecs[11] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         32'h0,         1'b1, 0};

        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            rsp_ready[d] = 1'b0;
        end

        #2;
        check("rst_req_ready", 32'(req_ready[0]), 32'(ready_in_rst));
        check("rst_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("rst_mem_read", 32'(mem_read[0]), 32'd0);
        check("rst_rsp_rdata", rsp_rdata[0], 32'd0);

        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
`ifdef DMEM_SCRUB_EN
        for (int i = 0; i < 32; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check("scrub_write", 32'(mem_write[0]), 32'd1);
            check("scrub_addr", 32'(mem_address[0]), 32'(i));
            check("scrub_data", mem_write_data[0], 32'd0);
            check("scrub_req_ready", 32'(req_ready[0]), 32'd0);
        end
        @(negedge clk);
        #1;
        check("scrub_done_ready", 32'(req_ready[0]), 32'd1);
`endif

        for (int i = 0; i < 12; i++) begin
            do_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].hold);
        end

        // Reset during the second wait cycle of an RD_LAT=3 load.
        do_txn(1, 1'b1, 32'h10, 32'h1111_2222, 32'h0, 1'b0, 0);
        @(negedge clk);
        #1;
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b0;
        req_addr[1]  = 32'h10;
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        check("mid_load_mem_read", 32'(mem_read[1]), 32'd1);
        rst = 1'b0;
        #1;
        check("rst_drop_mem_read", 32'(mem_read[1]), 32'd0);
        check("rst_drop_rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("rst_req_ready_mid", 32'(req_ready[1]), 32'(ready_in_rst));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("after_rst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
`ifndef DMEM_SCRUB_EN
        check("after_rst_req_ready", 32'(req_ready[1]), 32'd1);
`endif
        do_txn(1, 1'b1, 32'h7C, 32'h0BAD_F00D, 32'h0, 1'b0, 0);
        do_txn(1, 1'b0, 32'h7C, 32'h0, 32'h0BAD_F00D, 1'b0, 3);
        do_txn(1, 1'b0, 32'h7E, 32'h0, 32'h0, 1'b1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
